// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
// Issues word fetches over a valid/ready handshake and keeps up to DEPTH
// requests in flight. Returned words are buffered with their PC in a
// DEPTH-entry prefetch FIFO. A redirect flushes the FIFO and drops any stale
// in-flight responses.
// Optional feature macro: FETCH_MISALIGN_EN. When defined, misaligned redirect
// targets raise misalign_o and park fetch in FAULT. When undefined, the low
// target bits are forced to zero.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            req_ready_i,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    output logic            misalign_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   fifo_cnt, out_cnt, drop_cnt;
    logic [AW-1:0]   wr_ptr, rd_ptr, head_ptr;
    logic [AW-1:0]   pcq_wr, pcq_rd;
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_inst [DEPTH];
    logic [XLEN-1:0] pcq       [DEPTH];
    logic [CW:0]     credit;
    logic            accept, push, pop, misaligned;
    logic [XLEN-1:0] redirect_tgt;

    // Redirect target qualification: fault on misalignment, or silently align
    always_comb begin
        redirect_tgt = redirect_pc_i;
        misaligned   = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misaligned   = (redirect_pc_i[1:0] != 2'b00);
`else
        redirect_tgt = redirect_pc_i & ~XLEN'(3);
`endif
    end

    // Handshake and FIFO strobes; a redirect suppresses request, push and pop
    always_comb begin
        credit       = {1'b0, fifo_cnt} + {1'b0, out_cnt};
        req_valid_o  = rst_ni && (state == RUN) && !redirect_i && (credit < DEPTH_C);
        req_addr_o   = fetch_pc;
        accept       = req_valid_o && req_ready_i;
        inst_valid_o = (fifo_cnt != '0);
        pop          = inst_valid_o && inst_ready_i && !redirect_i;
        push         = rsp_valid_i && !redirect_i && (drop_cnt == '0) && (state == RUN);
        // When empty, show the most recently written slot so outputs hold
        head_ptr     = (fifo_cnt == '0) ? rd_ptr - 1'b1 : rd_ptr;
        inst_o       = fifo_inst[head_ptr];
        inst_pc_o    = fifo_pc[head_ptr];
`ifdef FETCH_MISALIGN_EN
        misalign_o   = (state == FAULT);
`else
        misalign_o   = 1'b0;
`endif
    end

    // Next-state logic: every redirect re-evaluates alignment of its target
    always_comb begin
        state_nxt = state;
        if (redirect_i) begin
            state_nxt = misaligned ? FAULT : RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC, credit counters and stale-response drop counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp_valid_i);
            if (redirect_i) begin
                fetch_pc <= redirect_tgt;
                fifo_cnt <= '0;
                // Everything still outstanding after this cycle is stale
                drop_cnt <= out_cnt - CW'(rsp_valid_i);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
                if (rsp_valid_i && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // FIFO and request-PC queue pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pcq_wr <= '0;
            pcq_rd <= '0;
        end else begin
            if (accept)      pcq_wr <= pcq_wr + 1'b1;
            if (rsp_valid_i) pcq_rd <= pcq_rd + 1'b1;
            if (redirect_i) begin
                wr_ptr <= rd_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Issued-address queue, popped in order as responses return
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    // Prefetch FIFO storage, cleared on reset so the head outputs read zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= pcq[pcq_rd];
            fifo_inst[wr_ptr] <= rsp_data_i;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the direct PC-to-IMEM path with a decoupled fetch stage. It issues word requests to an instruction memory of arbitrary latency over a valid/ready handshake and buffers returned instructions with their PC in a DEPTH-entry prefetch FIFO. It also handles branch/jump redirects from execute by flushing buffered and in-flight instructions.

## Interface
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch FIFO entries and maximum in-flight requests. Must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_o  out  1  fetch request valid.
- req_addr_o  out  XLEN  fetch address; word-aligned in normal operation.
- req_ready_i  in  1  memory accepts the request this cycle.
- rsp_valid_i  in  1  instruction word returned. Responses arrive in order, at least 1 cycle after acceptance.
- rsp_data_i  in  XLEN  returned instruction.
- redirect_i  in  1  PC redirect (taken branch/jump) from execute.
- redirect_pc_i  in  XLEN  redirect target.
- inst_valid_o  out  1  FIFO head valid.
- inst_o  out  XLEN  FIFO head instruction.
- inst_pc_o  out  XLEN  PC of the FIFO head.
- inst_ready_i  in  1  decode consumes the head this cycle.
- misalign_o  out  1  misaligned redirect fault. Driven only when FETCH_MISALIGN_EN is defined; tied 0 otherwise.

## Operation
- State registers:
  - fetch_pc: XLEN bits.
  - FIFO: DEPTH entries of {pc, inst}.
  - fifo_cnt and out_cnt (requests in flight): each $clog2(DEPTH)+1 bits.
  - drop_cnt: responses still to be discarded.
  - FSM state: RUN or FAULT.
- req_valid_o = (state==RUN) & !redirect_i & (fifo_cnt + out_cnt < DEPTH). req_addr_o = fetch_pc.
- Request acceptance (req_valid_o & req_ready_i):
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
  - out_cnt increments.
- Request PC tracking: a DEPTH-entry in-order queue of issued addresses is pushed on acceptance and popped on response.
- Response handling (rsp_valid_i):
  - out_cnt decrements.
  - If drop_cnt > 0: drop_cnt decrements and the data is discarded.
  - Otherwise {pc, rsp_data_i} is pushed to the FIFO. Overflow is impossible by the credit rule.
- Pop: on inst_valid_o & inst_ready_i. Push and pop in the same cycle leave fifo_cnt unchanged.
- Redirect (redirect_i=1 in cycle t):
  - FIFO cleared and any pop ignored; flush wins.
  - fetch_pc <= redirect_pc_i.
  - drop_cnt <= out_cnt - (rsp_valid_i ? 1 : 0).
  - Any response arriving in cycle t is discarded.
  - No request is issued in cycle t.
- A second redirect while drop_cnt > 0 recomputes drop_cnt by the same rule. Every response arriving before the first post-redirect request's response is discarded.
- FSM:
  - RUN -> FAULT on a misaligned redirect (macro only).
  - FAULT -> RUN on the next aligned redirect.
  - In FAULT: no requests; responses are still counted and dropped.

## Timing
- Reset values:
  - req_valid_o=0 while rst_ni=0.
  - req_addr_o=RESET_PC.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0, misalign_o=0.
  - All counters 0; state RUN.
- First request: req_valid_o=1 in the first cycle after rst_ni deasserts.
- Latency:
  - A response in cycle t is visible at inst_valid_o in cycle t+1, since FIFO outputs are registered storage.
  - Redirect in t: first request to the target in t+1.
  - Best-case redirect-to-inst_valid_o is 3 cycles, given memory latency 1.
- Throughput: one instruction/cycle sustained when memory latency ≤ DEPTH-1 and decode is always ready.
- Boundary conditions:
  - Full (fifo_cnt + out_cnt == DEPTH): req_valid_o=0. It reasserts the cycle after a pop.
  - Empty: inst_valid_o=0. inst_o/inst_pc_o hold their last value.
  - Reset mid-operation: all state clears immediately and asynchronously. Responses still in flight from memory after reset are the integration's responsibility; memory is reset together with this block.
- req_valid_o, once asserted, stays asserted with a stable address until accepted. The exception is redirect_i, which may withdraw it.

## Configuration
- FETCH_MISALIGN_EN, when defined:
  - A redirect with redirect_pc_i[1:0] != 0 flushes, enters FAULT and sets misalign_o=1 from the next cycle.
  - misalign_o is held until an aligned redirect.
  - fetch_pc is loaded with the faulting target.
- FETCH_MISALIGN_EN, when undefined:
  - redirect_pc_i[1:0] is forced to 0 and the FSM stays in RUN.
  - misalign_o=0 always.

## Test plan
- Reset release, memory latency 1, inst_ready_i=1 -> requests 0x0, 0x4, 0x8… on consecutive cycles. inst_pc_o=0x0 appears 2 cycles after release, then one instruction per cycle.
- DEPTH=4, inst_ready_i=0, memory always ready -> exactly 4 requests accepted, then req_valid_o=0. One pop -> exactly one further request (0x10).
- Latency 3 with 3 in flight, redirect_i=1 to 0x100 -> the 3 stale responses are dropped, FIFO empty. The next inst_pc_o is 0x100.
- Redirect in the same cycle as a response and a pop -> FIFO empty, that response dropped, drop_cnt = out_cnt-1. No request in that cycle.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
- FETCH_MISALIGN_EN defined, redirect to 0x102 -> misalign_o=1 next cycle, no requests. Redirect to 0x200 -> misalign_o=0 and a request to 0x200 follows.
